// File: rtl/accumulator_arbiter_pkg.sv
// Shared types and helpers for the accumulator_arbiter slice.
package accumulator_arbiter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StAccum,
    StSettle,
    StDone
  } state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
  import accumulator_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               valid
);

  // One spare bit so ptr + offset cannot overflow before the wrap.
  logic [ID_W:0] cand;

  // Scan offsets 0..NUM_REQ-1 from the pointer; the lowest offset wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(off);
      if (cand >= (ID_W + 1)'(NUM_REQ)) begin
        cand = cand - (ID_W + 1)'(NUM_REQ);
      end
      if (!valid && req[cand[ID_W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[ID_W-1:0];
      end
    end
    if (valid) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/accumulator_arbiter.sv
// Round-robin sharing of one external accumulator among NUM_REQ burst requesters.
// Optional feature: define ACC_ARB_TIMEOUT_EN to abort stalled bursts and add o_RESULT_ABORT.
module accumulator_arbiter
  import accumulator_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             i_CLK,
  input  logic                             i_RESET,
  input  logic [NUM_REQ-1:0]               i_REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_SUMMAND,
  input  logic [NUM_REQ-1:0]               i_LAST,
  output logic [NUM_REQ-1:0]               o_GRANT,
  output logic                             o_ACC_RESET,
  output logic                             o_ACC_CLK_ENABLE,
  output logic [DATA_WIDTH-1:0]            o_ACC_SUMMAND,
  input  logic [DATA_WIDTH-1:0]            i_ACCUMULATION,
  output logic [DATA_WIDTH-1:0]            o_RESULT,
  output logic [id_width(NUM_REQ)-1:0]     o_RESULT_ID,
  output logic                             o_RESULT_VALID,
`ifdef ACC_ARB_TIMEOUT_EN
  output logic                             o_RESULT_ABORT,
`endif
  input  logic                             i_RESULT_READY
);

  localparam int unsigned IdW = id_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("accumulator_arbiter: unsupported parameter values");
  end

  state_e               state_q, state_d;
  logic [IdW-1:0]       winner_q, winner_d;
  logic [NUM_REQ-1:0]   winner_oh_q, winner_oh_d;
  logic [IdW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 acc_reset_q, acc_reset_d;
  logic                 valid_q, valid_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [IdW-1:0]       result_id_q, result_id_d;
  logic                 accept;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IdW-1:0]       arb_idx;
  logic                 arb_valid;

`ifdef ACC_ARB_TIMEOUT_EN
  localparam int unsigned CntW = id_width(TIMEOUT_CYCLES);
  logic [CntW-1:0] stall_q, stall_d;
  logic            abort_q, abort_d;

  // Abort is only meaningful while the result is being offered.
  assign o_RESULT_ABORT = abort_q & valid_q;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (IdW)
  ) u_rr_arbiter (
    .req   (i_REQ),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Next-state, registered-output next values and the combinational accumulator drive.
  always_comb begin
    state_d          = state_q;
    winner_d         = winner_q;
    winner_oh_d      = winner_oh_q;
    ptr_d            = ptr_q;
    grant_d          = grant_q;
    acc_reset_d      = 1'b0;
    valid_d          = valid_q;
    result_d         = result_q;
    result_id_d      = result_id_q;
    o_ACC_CLK_ENABLE = 1'b0;
    o_ACC_SUMMAND    = '0;
    accept           = 1'b0;
`ifdef ACC_ARB_TIMEOUT_EN
    stall_d          = stall_q;
    abort_d          = abort_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          winner_d    = arb_idx;
          winner_oh_d = arb_grant;
          acc_reset_d = 1'b1;
          state_d     = StClear;
        end
      end
      StClear: begin
        grant_d = winner_oh_q;
        state_d = StAccum;
`ifdef ACC_ARB_TIMEOUT_EN
        stall_d = '0;
`endif
      end
      StAccum: begin
        o_ACC_CLK_ENABLE = i_REQ[winner_q];
        o_ACC_SUMMAND    = i_SUMMAND[32'(winner_q)*DATA_WIDTH +: DATA_WIDTH];
        accept           = i_REQ[winner_q] & grant_q[winner_q];
        if (accept && i_LAST[winner_q]) begin
          grant_d = '0;
          state_d = StSettle;
        end
`ifdef ACC_ARB_TIMEOUT_EN
        else if (accept) begin
          stall_d = '0;
        end else if (stall_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          grant_d = '0;
          abort_d = 1'b1;
          state_d = StSettle;
        end else begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
      StSettle: begin
        // The accumulator absorbed the last beat on the previous edge.
        result_d    = i_ACCUMULATION;
        result_id_d = winner_q;
        valid_d     = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (i_RESULT_READY) begin
          valid_d = 1'b0;
          ptr_d   = (winner_q == IdW'(NUM_REQ - 1)) ? '0 : winner_q + 1'b1;
          state_d = StIdle;
`ifdef ACC_ARB_TIMEOUT_EN
          abort_d = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset abandons any burst in flight.
  always_ff @(posedge i_CLK or negedge i_RESET) begin
    if (!i_RESET) begin
      state_q     <= StIdle;
      winner_q    <= '0;
      winner_oh_q <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      acc_reset_q <= 1'b0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      result_id_q <= '0;
`ifdef ACC_ARB_TIMEOUT_EN
      stall_q     <= '0;
      abort_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      winner_oh_q <= winner_oh_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      acc_reset_q <= acc_reset_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
      result_id_q <= result_id_d;
`ifdef ACC_ARB_TIMEOUT_EN
      stall_q     <= stall_d;
      abort_q     <= abort_d;
`endif
    end
  end

  assign o_GRANT        = grant_q;
  assign o_ACC_RESET    = acc_reset_q;
  assign o_RESULT       = result_q;
  assign o_RESULT_ID    = result_id_q;
  assign o_RESULT_VALID = valid_q;

endmodule
